// File: rtl/nrzi_decoder.sv
// NRZI line decoder: sync hunt, LSB-first byte assembly and end-of-packet framing.
// Define NRZI_DEC_DESTUFF_EN to enable removal of the bit following six consecutive 1s.
module nrzi_decoder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       line_en,
    input  logic       din,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       sop,
    output logic       eop,
    output logic       err
);

    typedef enum logic {StHunt, StData} state_e;

    // Newest decoded bit enters at the MSB, so seven 0s then a 1 reads as 8'h80.
    localparam logic [7:0] SyncPattern = 8'h80;

    state_e     state_q, state_d;
    logic       prev_line_q, prev_line_d;
    logic [7:0] sync_q, sync_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] data_q, data_d;
    logic       data_valid_q, data_valid_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       err_q, err_d;

    logic       dec_bit;
    logic       keep_bit;
    logic [7:0] sync_shift;

`ifdef NRZI_DEC_DESTUFF_EN
    localparam logic [2:0] StuffLimit = 3'd6;
    logic [2:0] ones_cnt_q, ones_cnt_d;
`endif

    assign dec_bit    = (din == prev_line_q);
    assign sync_shift = {dec_bit, sync_q[7:1]};

    always_comb begin
        state_d      = state_q;
        prev_line_d  = prev_line_q;
        sync_d       = sync_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        err_d        = 1'b0;
        keep_bit     = 1'b0;
`ifdef NRZI_DEC_DESTUFF_EN
        ones_cnt_d   = ones_cnt_q;
`endif

        if (!line_en) begin
            prev_line_d = 1'b1;
            sync_d      = 8'hFF;
            if (state_q == StData) begin
                eop_d     = 1'b1;
                err_d     = (bit_cnt_q != 3'd0);
                state_d   = StHunt;
                bit_cnt_d = 3'd0;
                byte_d    = 8'h00;
`ifdef NRZI_DEC_DESTUFF_EN
                ones_cnt_d = 3'd0;
`endif
            end
        end else begin
            prev_line_d = din;
            unique case (state_q)
                StHunt: begin
                    sync_d = sync_shift;
                    if (sync_shift == SyncPattern) begin
                        state_d   = StData;
                        sop_d     = 1'b1;
                        sync_d    = 8'hFF;
                        bit_cnt_d = 3'd0;
                        byte_d    = 8'h00;
`ifdef NRZI_DEC_DESTUFF_EN
                        ones_cnt_d = 3'd1;
`endif
                    end
                end
                StData: begin
`ifdef NRZI_DEC_DESTUFF_EN
                    if (ones_cnt_q == StuffLimit) begin
                        ones_cnt_d = 3'd0;
                        if (dec_bit) begin
                            err_d     = 1'b1;
                            state_d   = StHunt;
                            bit_cnt_d = 3'd0;
                            byte_d    = 8'h00;
                        end
                    end else begin
                        keep_bit   = 1'b1;
                        ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                    end
`else
                    keep_bit = 1'b1;
`endif
                    if (keep_bit) begin
                        byte_d[bit_cnt_q] = dec_bit;
                        bit_cnt_d         = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d       = byte_d;
                            data_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StHunt;
            prev_line_q  <= 1'b1;
            sync_q       <= 8'hFF;
            bit_cnt_q    <= 3'd0;
            byte_q       <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
`ifdef NRZI_DEC_DESTUFF_EN
            ones_cnt_q   <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            prev_line_q  <= prev_line_d;
            sync_q       <= sync_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
`ifdef NRZI_DEC_DESTUFF_EN
            ones_cnt_q   <= ones_cnt_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign err        = err_q;

endmodule
